mxint_mul: RTL and testbench

- Element-wise MXINT block multiplier. Joins two MXINT block streams, each a BLOCK_SIZE vector of signed mantissas plus one shared signed exponent, and emits their product block.
- Inverse-direction companion to the attention-path MXINT divider: it rescales normalised scores and values back up.
- Two-stage registered pipeline, one block per cycle, full valid/ready backpressure on all three streams.

---
 rtl/mxint_pkg.sv | 25 ++
 rtl/mxint_pipe_reg.sv | 28 ++
 rtl/mxint_mul.sv | 107 ++++++++++
 tb/tb_mxint_mul.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mxint_pkg.sv
// Shared helpers for the MXINT arithmetic blocks: product sizing and
// signed saturation of exponents.
package mxint_pkg;

  // Full-precision width of a signed a_w x b_w bit product.
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clamp a signed value into the two's complement range of 'width' bits.
  function automatic int sat_signed(input int value, input int width);
    int hi;
    int lo;
    hi = (1 <<< (width - 1)) - 1;
    lo = -hi - 1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/mxint_pipe_reg.sv
// One valid/ready register slice: a stalled slice holds data and valid,
// and it refills in the same cycle it drains.
module mxint_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/mxint_mul.sv
// Element-wise MXINT block multiplier: joins two block streams, registers the
// full products (S1), then rescales mantissas and saturates the exponent (S2).
//
// Handshake: a stream transfers on a rising edge where its valid and ready are
// both high; valid never depends on ready, and a held block stays unchanged.
module mxint_mul
  import mxint_pkg::*;
#(
  parameter int DATA_IN_0_PRECISION_0 = 8,
  parameter int DATA_IN_0_PRECISION_1 = 8,
  parameter int DATA_IN_1_PRECISION_0 = 8,
  parameter int DATA_IN_1_PRECISION_1 = 8,
  parameter int DATA_OUT_PRECISION_0  = 8,
  parameter int DATA_OUT_PRECISION_1  = 8,
  parameter int BLOCK_SIZE            = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0] mdata_in_0 [BLOCK_SIZE],
  input  logic [DATA_IN_0_PRECISION_1-1:0] edata_in_0,
  input  logic                             data_in_0_valid,
  output logic                             data_in_0_ready,
  input  logic [DATA_IN_1_PRECISION_0-1:0] mdata_in_1 [BLOCK_SIZE],
  input  logic [DATA_IN_1_PRECISION_1-1:0] edata_in_1,
  input  logic                             data_in_1_valid,
  output logic                             data_in_1_ready,
  output logic [DATA_OUT_PRECISION_0-1:0]  mdata_out [BLOCK_SIZE],
  output logic [DATA_OUT_PRECISION_1-1:0]  edata_out,
  output logic                             data_out_valid,
  input  logic                             data_out_ready
);

  localparam int PW    = prod_width(DATA_IN_0_PRECISION_0, DATA_IN_1_PRECISION_0);
  localparam int SHIFT = PW - DATA_OUT_PRECISION_0;
  localparam int ESW   = max_int(DATA_IN_0_PRECISION_1, DATA_IN_1_PRECISION_1) + 1;
  localparam int MOW   = DATA_OUT_PRECISION_0;
  localparam int EOW   = DATA_OUT_PRECISION_1;
  localparam int S1W   = BLOCK_SIZE * PW + ESW;
  localparam int S2W   = BLOCK_SIZE * MOW + EOW;

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("mxint_mul: output mantissa wider than the full product");
    end
  endgenerate

  logic           s1_accept, s1_valid, s2_accept, join_valid;
  logic [S1W-1:0] s1_in, s1_out;
  logic [S2W-1:0] s2_in, s2_out;

  // Reset gates the join so neither input is acknowledged while in reset.
  assign join_valid      = data_in_0_valid && data_in_1_valid && !rst;
  assign data_in_0_ready = data_in_1_valid && s1_accept && !rst;
  assign data_in_1_ready = data_in_0_valid && s1_accept && !rst;

  always_comb begin
    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    s1_in = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      a_ext = PW'($signed(mdata_in_0[i]));
      b_ext = PW'($signed(mdata_in_1[i]));
      s1_in[i*PW +: PW] = a_ext * b_ext;
    end
    s1_in[S1W-1 -: ESW] = ESW'($signed(edata_in_0)) + ESW'($signed(edata_in_1));
  end

  mxint_pipe_reg #(.W(S1W)) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s1_in),
    .in_valid  (join_valid),
    .in_ready  (s1_accept),
    .out_data  (s1_out),
    .out_valid (s1_valid),
    .out_ready (s2_accept)
  );

  // Floor-rescale the products; the exponent absorbs the shift and saturates.
  always_comb begin
    s2_in = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      s2_in[i*MOW +: MOW] = MOW'($signed(s1_out[i*PW +: PW]) >>> SHIFT);
    end
    s2_in[S2W-1 -: EOW] =
      EOW'(sat_signed(int'($signed(s1_out[S1W-1 -: ESW])) + SHIFT, EOW));
  end

  mxint_pipe_reg #(.W(S2W)) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (s2_in),
    .in_valid  (s1_valid),
    .in_ready  (s2_accept),
    .out_data  (s2_out),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready)
  );

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      mdata_out[i] = s2_out[i*MOW +: MOW];
    end
    edata_out = s2_out[S2W-1 -: EOW];
  end

endmodule

// File: tb/tb_mxint_mul.sv
// Directed bench for mxint_mul with a scoreboard of expected product blocks
// and a monitor checking order, output stability and unexpected outputs.
module tb_mxint_mul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mdata_in_0 [4];
  logic [7:0]  mdata_in_1 [4];
  logic [7:0]  edata_in_0, edata_in_1;
  logic        data_in_0_valid, data_in_0_ready;
  logic        data_in_1_valid, data_in_1_ready;
  logic [7:0]  mdata_out [4];
  logic [7:0]  edata_out;
  logic        data_out_valid, data_out_ready;

  logic [31:0] a_bus, b_bus;
  logic [39:0] dut_out;
  logic [39:0] exp_q[$];
  logic [39:0] last_out, prev_out;
  logic        prev_stall;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          out_cnt = 0;
  int          base;

  always #5 clk = ~clk;

  mxint_mul dut (
    .clk             (clk),
    .rst             (rst),
    .mdata_in_0      (mdata_in_0),
    .edata_in_0      (edata_in_0),
    .data_in_0_valid (data_in_0_valid),
    .data_in_0_ready (data_in_0_ready),
    .mdata_in_1      (mdata_in_1),
    .edata_in_1      (edata_in_1),
    .data_in_1_valid (data_in_1_valid),
    .data_in_1_ready (data_in_1_ready),
    .mdata_out       (mdata_out),
    .edata_out       (edata_out),
    .data_out_valid  (data_out_valid),
    .data_out_ready  (data_out_ready)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mdata_in_0[i] = a_bus[i*8 +: 8];
      mdata_in_1[i] = b_bus[i*8 +: 8];
    end
  end
  assign dut_out = {edata_out, mdata_out[3], mdata_out[2], mdata_out[1], mdata_out[0]};

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: exact integer product, floor division by 2^8, clamped exponent.
  function automatic logic [39:0] model(input logic [31:0] a, input logic [7:0] ea,
                                        input logic [31:0] b, input logic [7:0] eb);
    logic [39:0] r;
    int p, q, e;
    for (int i = 0; i < 4; i++) begin
      p = int'($signed(a[i*8 +: 8])) * int'($signed(b[i*8 +: 8]));
      q = p / 256;
      if (p < 0 && q * 256 != p) q = q - 1;
      r[i*8 +: 8] = q[7:0];
    end
    e = int'($signed(ea)) + int'($signed(eb)) + 8;
    if (e > 127) e = 127;
    if (e < -128) e = -128;
    r[39:32] = e[7:0];
    return r;
  endfunction

  // Caller is at a falling edge; returns at the falling edge after the handshake.
  task automatic xfer(input logic [31:0] a, input logic [7:0] ea,
                      input logic [31:0] b, input logic [7:0] eb);
    a_bus = a; edata_in_0 = ea; b_bus = b; edata_in_1 = eb;
    data_in_0_valid = 1'b1; data_in_1_valid = 1'b1;
    #1;
    for (int n = 0; n < 100 && !(data_in_0_ready && data_in_1_ready); n++) begin
      @(negedge clk); #1;
    end
    chk("xfer_accept", {38'd0, data_in_0_ready, data_in_1_ready}, 40'd3);
    exp_q.push_back(model(a, ea, b, eb));
    @(negedge clk);
    data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
  endtask

  // Called right after xfer with data_out_ready high and an empty pipeline.
  task automatic lat_check(input string tag, input logic [39:0] exp);
    #1;
    chk({tag, "_lat1"}, {39'd0, data_out_valid}, 40'd0);
    @(negedge clk); #1;
    chk({tag, "_lat2"}, {39'd0, data_out_valid}, 40'd1);
    chk(tag, dut_out, exp);
    @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", 40'(exp_q.size()), 40'd0);
  endtask

  // Monitor samples between edges, after inputs have settled.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {39'd0, data_out_valid}, 40'd1);
        chk("stall_stable", dut_out, prev_out);
      end
      if (data_out_valid && data_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", dut_out, 40'hx);
        end else begin
          chk("sb_out", dut_out, exp_q.pop_front());
        end
        last_out = dut_out;
        out_cnt++;
      end
      prev_stall = data_out_valid && !data_out_ready;
      prev_out   = dut_out;
    end
  end

  initial begin
    a_bus = '0; b_bus = '0; edata_in_0 = '0; edata_in_1 = '0;
    data_in_0_valid = 1'b1; data_in_1_valid = 1'b1; data_out_ready = 1'b1;
    prev_stall = 1'b0; prev_out = '0; last_out = '0;

    // Reset: readies gated, outputs cleared.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready0", {39'd0, data_in_0_ready}, 40'd0);
    chk("rst_ready1", {39'd0, data_in_1_ready}, 40'd0);
    chk("rst_valid", {39'd0, data_out_valid}, 40'd0);
    chk("rst_data", dut_out, 40'd0);
    @(negedge clk);
    rst = 1'b0; data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
    @(negedge clk);

    // Basic product, SHIFT=8.
    xfer(32'hFC03FE01, 8'h02, 32'h80FF0505, 8'hFD);
    lat_check("basic", 40'h07_02_FF_FF_00);
    wait_drain();

    // Join: lone A is never consumed.
    base = out_cnt;
    a_bus = 32'h04030201; edata_in_0 = 8'h01; data_in_0_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("join_ready0_low", {39'd0, data_in_0_ready}, 40'd0);
      chk("join_no_out", 40'(out_cnt), 40'(base));
      @(negedge clk);
    end
    b_bus = 32'h7F7F7F7F; edata_in_1 = 8'h00; data_in_1_valid = 1'b1;
    #1;
    chk("join_ready0", {39'd0, data_in_0_ready}, 40'd1);
    chk("join_ready1", {39'd0, data_in_1_ready}, 40'd1);
    exp_q.push_back(model(32'h04030201, 8'h01, 32'h7F7F7F7F, 8'h00));
    @(negedge clk);
    data_in_0_valid = 1'b0; data_in_1_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("join_one_out", 40'(out_cnt), 40'(base + 1));

    // Backpressure: four random blocks against a stalled output.
    base = out_cnt;
    data_out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          xfer($urandom_range(32'hFFFFFFFF, 0), 8'($urandom_range(255, 0)),
               $urandom_range(32'hFFFFFFFF, 0), 8'($urandom_range(255, 0)));
        end
      end
      begin
        repeat (4) @(negedge clk);
        #1;
        chk("bp_in_stalled", {39'd0, data_in_0_ready}, 40'd0);
        chk("bp_held", 40'(exp_q.size()), 40'd2);
        chk("bp_no_out", 40'(out_cnt), 40'(base));
        @(negedge clk);
        data_out_ready = 1'b1;
      end
    join
    wait_drain();
    repeat (3) @(negedge clk);
    chk("bp_four_out", 40'(out_cnt), 40'(base + 4));

    // Exponent saturation at both ends.
    xfer(32'h01010101, 8'd100, 32'h01010101, 8'd100);
    lat_check("sat_hi", 40'h7F_00000000);
    xfer(32'h01010101, 8'h80, 32'h01010101, 8'h80);
    lat_check("sat_lo", 40'h80_00000000);

    // Extreme mantissas: -128*-128 and -128*127.
    xfer(32'h80808080, 8'h00, 32'h7F807F80, 8'h00);
    lat_check("extreme", 40'h08_C040C040);
    wait_drain();

    // Asynchronous reset with two blocks in flight and the output stalled.
    data_out_ready = 1'b0;
    xfer(32'h11223344, 8'h05, 32'h55667788, 8'h06);
    xfer(32'h01020304, 8'h01, 32'h05060708, 8'h02);
    #1;
    chk("pre_rst_valid", {39'd0, data_out_valid}, 40'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", {39'd0, data_out_valid}, 40'd0);
    chk("rst_async_data", dut_out, 40'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0; data_out_ready = 1'b1;
    base = out_cnt;
    repeat (5) @(negedge clk);
    chk("rst_no_stale", 40'(out_cnt), 40'(base));
    xfer(32'h10101010, 8'h01, 32'h20202020, 8'h01);
    lat_check("post_rst", 40'h0A_02020202);
    wait_drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
